// File: rtl/data_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_responder_if: processor access port and output-FIFO stream port       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface data_responder_if;
  logic        req;
  logic        mem_write;
  logic [15:0] address;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output req, mem_write, address, write_data, out_ready,
    input  read_data, ready, out_data, out_valid
  );

  modport slave (
    input  req, mem_write, address, write_data, out_ready,
    output read_data, ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/data_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_responder: wait-stated memory-mapped RAM, output FIFO and status regs |
// | Option macro: DATA_RESPONDER_CYCLE_COUNTER_EN (CYCLES counter at 0xFF02)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module data_responder #(
  parameter int RAM_WORDS   = 256,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 1
) (
  input  wire             clock,
  input  wire             reset,
  data_responder_if.slave bus
);
  localparam logic [1:0]  c_idle = 2'd0;
  localparam logic [1:0]  c_wait = 2'd1;
  localparam logic [1:0]  c_resp = 2'd2;
  localparam int          c_ram_aw = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int          c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int          c_cnt_w  = c_ptr_w + 1;
  localparam logic [3:0]  c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [16:0] c_ram_lim   = 17'(RAM_WORDS);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);
  localparam logic [15:0] c_fifo_addr   = 16'hFF00;
  localparam logic [15:0] c_status_addr = 16'hFF01;
  localparam logic [15:0] c_cycles_addr = 16'hFF02;

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        w_commit;

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic        overflow_q, overflow_d;

  logic [15:0] w_acc_addr, w_acc_data, w_cycles, w_rd_val;
  logic        w_wr, w_ram_we, w_push, w_push_ok, w_pop, w_full, w_status_wr;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= c_idle;
    else        state_q <= state_d;
  end

  // Next state; w_commit marks the edge that enters RESP (write side effect)
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    w_commit = 1'b0;
    case (state_q)
      c_idle: if (bus.req) begin
        if (WAIT_STATES == 0) begin
          state_d  = c_resp;
          w_commit = 1'b1;
        end else begin
          state_d = c_wait;
          wait_d  = c_wait_init;
        end
      end
      c_wait: if (wait_q == 4'd0) begin
        state_d  = c_resp;
        w_commit = 1'b1;
      end else begin
        wait_d = wait_q - 4'd1;
      end
      c_resp:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ready     = (state_q == c_resp);
    bus.read_data = (bus.ready && !we_q) ? w_rd_val : 16'h0000;
    bus.out_valid = (count_q != '0);
    bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
  end

  // With zero wait states the commit happens in IDLE, before the request is latched
  always_comb begin
    w_acc_addr  = (state_q == c_idle) ? bus.address    : addr_q;
    w_acc_data  = (state_q == c_idle) ? bus.write_data : wdata_q;
    w_wr        = w_commit && ((state_q == c_idle) ? bus.mem_write : we_q);
    w_ram_we    = w_wr && ({1'b0, w_acc_addr} < c_ram_lim);
    w_push      = w_wr && (w_acc_addr == c_fifo_addr);
    w_status_wr = w_wr && (w_acc_addr == c_status_addr);
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if (state_q == c_idle && bus.req) begin
      addr_d  = bus.address;
      wdata_d = bus.write_data;
      we_d    = bus.mem_write;
    end
  end

  // FIFO: a pop frees the slot a simultaneous push needs, even when full
  always_comb begin
    w_full     = (count_q == c_full);
    w_pop      = (count_q != '0) && bus.out_ready;
    w_push_ok  = w_push && (!w_full || w_pop);
    wr_ptr_d   = w_push_ok ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
    rd_ptr_d   = w_pop     ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
    count_d    = count_q;
    if (w_push_ok && !w_pop)      count_d = count_q + c_cnt_w'(1);
    else if (!w_push_ok && w_pop) count_d = count_q - c_cnt_w'(1);
    overflow_d = overflow_q;
    if (w_status_wr)                      overflow_d = 1'b0;
    else if (w_push && w_full && !w_pop)  overflow_d = 1'b1;
  end

  always_comb begin
    w_rd_val = 16'h0000;
    if ({1'b0, addr_q} < c_ram_lim) w_rd_val = ram[addr_q[c_ram_aw-1:0]];
    else if (addr_q == c_status_addr) w_rd_val = {overflow_q, 7'b0, 8'(count_q)};
    else if (addr_q == c_cycles_addr) w_rd_val = w_cycles;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_q     <= 4'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      we_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM survives reset; only the write is blocked while reset is asserted
  always_ff @(posedge clock) begin
    if (reset && w_ram_we) ram[w_acc_addr[c_ram_aw-1:0]] <= w_acc_data;
  end

  always_ff @(posedge clock) begin
    if (reset && w_push_ok) fifo_mem[wr_ptr_q] <= w_acc_data;
  end

`ifdef DATA_RESPONDER_CYCLE_COUNTER_EN
  logic [15:0] cycles_q, cycles_d;
  logic        w_cyc_wr;

  always_comb begin
    w_cyc_wr = w_wr && (w_acc_addr == c_cycles_addr);
    cycles_d = w_cyc_wr ? 16'h0000 : cycles_q + 16'h0001;
  end

  always_ff @(posedge clock) begin
    if (!reset) cycles_q <= 16'h0000;
    else        cycles_q <= cycles_d;
  end

  assign w_cycles = cycles_q;
`else
  assign w_cycles = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_responder.sv
`default_nettype none
// Scoreboard bench for data_responder: directed accesses push expected responses,
// a forked monitor checks ready timing, read data and FIFO pop order.
module tb_data_responder;
  localparam int WS = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    string       nm;
    bit          chk;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] fifo_q[$];

  data_responder_if bus();

  data_responder #(.RAM_WORDS(256), .FIFO_DEPTH(4), .WAIT_STATES(WS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic [15:0] f;
    forever begin
      @(negedge clock);
      if (bus.ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_ready", 16'h1, 16'h0);
        end else begin
          e = sb_q.pop_front();
          check({e.nm, "_ready_cycle"}, 16'(cyc), 16'(e.cyc));
          if (e.chk) check(e.nm, bus.read_data, e.val);
        end
      end else begin
        check("read_data_idle", bus.read_data, 16'h0000);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (fifo_q.size() == 0) begin
          check("unexpected_pop", 16'h1, 16'h0);
        end else begin
          f = fifo_q.pop_front();
          check("fifo_pop", bus.out_data, f);
        end
      end
      if (!bus.out_valid) check("out_data_empty", bus.out_data, 16'h0000);
    end
  endtask

  task automatic start_req(input bit we, input logic [15:0] a, input logic [15:0] d,
                           input bit chk, input logic [15:0] exp, input string nm);
    @(posedge clock); #1;
    bus.req = 1'b1; bus.mem_write = we; bus.address = a; bus.write_data = d;
    sb_q.push_back('{nm, chk, exp, cyc + WS + 1});
  endtask

  // Holds req for 'hold' cycles, then waits until the FSM is back in IDLE
  task automatic end_req(input int hold);
    repeat (hold) @(posedge clock);
    #1 bus.req = 1'b0;
    if (hold < WS + 2) repeat (WS + 2 - hold) @(posedge clock);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    start_req(1'b1, a, d, 1'b0, 16'h0, "write");
    end_req(1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    start_req(1'b0, a, 16'h0, 1'b1, exp, nm);
    end_req(1);
  endtask

  initial begin
    int t0;
    bus.req = 1'b0; bus.mem_write = 1'b0; bus.address = 16'h0;
    bus.write_data = 16'h0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    fork monitor(); join_none

    @(negedge clock);
    check("reset_ready", 16'(bus.ready), 16'h0);
    check("reset_read_data", bus.read_data, 16'h0000);
    check("reset_out_valid", 16'(bus.out_valid), 16'h0);
    check("reset_out_data", bus.out_data, 16'h0000);

    // RAM write then read-back, ready timing checked by monitor
    wr(16'h0010, 16'h1234);
    rd(16'h0010, 16'h1234, "ram_readback");
    rd(16'hFF01, 16'h0000, "status_after_reset");

    // Fill FIFO past full with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      wr(16'hFF00, 16'h00A1 + 16'(i));
      if (i < 4) fifo_q.push_back(16'h00A1 + 16'(i));
    end
    rd(16'hFF01, 16'h8004, "status_overflow");
    @(negedge clock);
    check("head_a1", bus.out_data, 16'h00A1);
    check("valid_full", 16'(bus.out_valid), 16'h1);
    wr(16'hFF01, 16'hFFFF);
    rd(16'hFF01, 16'h0004, "status_cleared");
    rd(16'hFF00, 16'h0000, "fifo_port_read");

    // Push into a full FIFO in the same cycle as a pop
    start_req(1'b1, 16'hFF00, 16'h00B0, 1'b0, 16'h0, "push_pop");
    fifo_q.push_back(16'h00B0);
    if (WS == 0) bus.out_ready = 1'b1;
    @(posedge clock); #1 bus.req = 1'b0;
    if (WS > 0) begin
      repeat (WS - 1) @(posedge clock);
      #1 bus.out_ready = 1'b1;
      @(posedge clock);
    end
    #1 bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    rd(16'hFF01, 16'h0004, "status_push_pop");
    @(posedge clock); #1 bus.out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1 bus.out_ready = 1'b0;
    @(negedge clock);
    check("drained_valid", 16'(bus.out_valid), 16'h0);
    check("drained_all", 16'(fifo_q.size()), 16'h0);

    // req held through WAIT and RESP must give a single response
    start_req(1'b0, 16'h0010, 16'h0, 1'b1, 16'h1234, "held_req");
    end_req(WS + 2);
    wr(16'h0000, 16'h5555);
    rd(16'h4000, 16'h0000, "unmapped_read");
    wr(16'h4000, 16'hBEEF);
    rd(16'h0000, 16'h5555, "no_alias_write");
    rd(16'hFF01, 16'h0000, "status_unchanged");
    rd(16'hFF03, 16'h0000, "unmapped_ff03");

    // CYCLES: clear, then read with req issued 10 cycles after the clearing req
    start_req(1'b1, 16'hFF02, 16'h0, 1'b0, 16'h0, "cycles_clear");
    t0 = cyc;
    end_req(1);
    while (cyc < t0 + 9) begin @(posedge clock); #1; end
`ifdef DATA_RESPONDER_CYCLE_COUNTER_EN
    start_req(1'b0, 16'hFF02, 16'h0, 1'b1, 16'd10, "cycles_read");
`else
    start_req(1'b0, 16'hFF02, 16'h0, 1'b1, 16'h0000, "cycles_read");
`endif
    end_req(1);

    // Reset in the WAIT cycle of a FIFO push aborts it
    wr(16'hFF00, 16'h00C1);
    fifo_q.push_back(16'h00C1);
    @(posedge clock); #1;
    bus.req = 1'b1; bus.mem_write = 1'b1; bus.address = 16'hFF00; bus.write_data = 16'h00C2;
    @(posedge clock); #1;
    bus.req = 1'b0; reset = 1'b0;
    fifo_q.delete();
    @(posedge clock); #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    check("abort_out_valid", 16'(bus.out_valid), 16'h0);
    rd(16'hFF01, 16'h0000, "abort_status");
    rd(16'h0010, 16'h1234, "ram_kept");

    repeat (3) @(posedge clock);
    check("scoreboard_empty", 16'(sb_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
